// File: rtl/gcd_pkg.sv
// gcd_pkg: shared definitions for the GCD unit test harness.
//   - message widths for the response (GCD_MSG_W) and request (GCD_REQ_W) streams
//   - sink FSM state encoding
//   - operand pairs sent by the request source and the matching GCD results
//     expected by the response sink, kept side by side so they cannot drift
package gcd_pkg;

  localparam int GCD_MSG_W = 16;
  localparam int GCD_REQ_W = 32;

  typedef enum logic [1:0] {
    RECV = 2'd0,
    DONE = 2'd1,
    TMO  = 2'd2
  } sink_state_e;

  // Operand pairs {a, b} issued by the source, in order.
  localparam logic [GCD_MSG_W-1:0] GCD_OPA_0 = 16'd15;
  localparam logic [GCD_MSG_W-1:0] GCD_OPB_0 = 16'd10;
  localparam logic [GCD_MSG_W-1:0] GCD_OPA_1 = 16'd4;
  localparam logic [GCD_MSG_W-1:0] GCD_OPB_1 = 16'd6;
  localparam logic [GCD_MSG_W-1:0] GCD_OPA_2 = 16'd36;
  localparam logic [GCD_MSG_W-1:0] GCD_OPB_2 = 16'd54;
  localparam logic [GCD_MSG_W-1:0] GCD_OPA_3 = 16'd9;
  localparam logic [GCD_MSG_W-1:0] GCD_OPB_3 = 16'd12;

  // gcd() of each pair above.
  localparam logic [GCD_MSG_W-1:0] GCD_EXP_0 = 16'd5;
  localparam logic [GCD_MSG_W-1:0] GCD_EXP_1 = 16'd2;
  localparam logic [GCD_MSG_W-1:0] GCD_EXP_2 = 16'd18;
  localparam logic [GCD_MSG_W-1:0] GCD_EXP_3 = 16'd3;

  function automatic logic [GCD_MSG_W-1:0] gcd_exp(input logic [1:0] idx);
    case (idx)
      2'd0:    return GCD_EXP_0;
      2'd1:    return GCD_EXP_1;
      2'd2:    return GCD_EXP_2;
      default: return GCD_EXP_3;
    endcase
  endfunction

  function automatic logic [GCD_REQ_W-1:0] gcd_req(input logic [1:0] idx);
    case (idx)
      2'd0:    return {GCD_OPA_0, GCD_OPB_0};
      2'd1:    return {GCD_OPA_1, GCD_OPB_1};
      2'd2:    return {GCD_OPA_2, GCD_OPB_2};
      default: return {GCD_OPA_3, GCD_OPB_3};
    endcase
  endfunction

endpackage

// File: rtl/gcd_sink_if.sv
// gcd_sink_if: val/rdy response stream carrying one GCD result per handshake.
//   val : result valid (driven by the GCD unit)
//   rdy : sink ready (driven by the sink)
//   msg : GCD result, GCD_MSG_W bits
// Modports: master = GCD unit side, slave = sink side.
interface gcd_sink_if;
  import gcd_pkg::*;

  logic                 val;
  logic                 rdy;
  logic [GCD_MSG_W-1:0] msg;

  modport master (output val, output msg, input rdy);
  modport slave  (input val, input msg, output rdy);

endinterface

// File: rtl/gcd_sink_lfsr.sv
// gcd_sink_lfsr: 8-bit Fibonacci LFSR, polynomial x^8 + x^6 + x^5 + x^4 + 1.
// Loads seed on reset, shifts left one step per enabled cycle.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset (loads seed)
//   en    : step enable
//   seed  : reset value (must be nonzero)
//   q     : current LFSR state
module gcd_sink_lfsr (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic fb;

  // Taps 8,6,5,4 map to bits 7,5,4,3.
  assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= seed;
    end else if (en) begin
      q <= {q[6:0], fb};
    end
  end

endmodule

// File: rtl/gcd_sink.sv
// gcd_sink: response sink for the GCD unit test top.
// Accepts four results over a val/rdy stream, checks each in order against
// the expected table in gcd_pkg, counts mismatches and flags a stalled stream.
//
//   state | meaning
//   RECV  | accepting results; timeout counter running
//   DONE  | all results received (terminal)
//   TMO   | no handshake within TIMEOUT cycles (terminal)
//
// Ports:
//   clk       : clock
//   reset     : synchronous active-high reset
//   resp      : gcd_sink_if.slave response stream (val, rdy, msg)
//   done      : all results received or timeout hit
//   pass      : done with no mismatches and no timeout
//   err_count : number of mismatched results
//   timeout   : sticky, stream stalled past TIMEOUT
//   fail_idx  : index of first mismatch (meaningful when err_count != 0)
// Parameters:
//   TIMEOUT   : cycles allowed without a handshake (>= 1)
//   NUM_MSGS  : results expected; the table holds exactly 4
// Build option:
//   GCD_SINK_STALL_EN : when defined, an LFSR randomly drops rdy in RECV to
//                       exercise backpressure on the GCD unit.
module gcd_sink
  import gcd_pkg::*;
#(
  parameter int TIMEOUT  = 1024,
  parameter int NUM_MSGS = 4
) (
  input  logic            clk,
  input  logic            reset,
  gcd_sink_if.slave       resp,
  output logic            done,
  output logic            pass,
  output logic [2:0]      err_count,
  output logic            timeout,
  output logic [1:0]      fail_idx
);

  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0]       IDX_LAST = 2'(NUM_MSGS - 1);

  sink_state_e      state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [2:0]       err_nxt;
  logic [1:0]       fail_idx_nxt;
  logic             timeout_nxt;
  logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic             stall;
  logic             fire;

`ifdef GCD_SINK_STALL_EN
  logic [7:0] lfsr_q;

  gcd_sink_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .seed  (8'hA5),
    .q     (lfsr_q)
  );

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // rdy depends only on registered state, never on val.
  assign resp.rdy = (state == RECV) && !stall;
  assign fire     = resp.val && resp.rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RECV;
      idx       <= 2'd0;
      err_count <= 3'd0;
      fail_idx  <= 2'd0;
      timeout   <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      err_count <= err_nxt;
      fail_idx  <= fail_idx_nxt;
      timeout   <= timeout_nxt;
      tmo_cnt   <= tmo_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    err_nxt      = err_count;
    fail_idx_nxt = fail_idx;
    timeout_nxt  = timeout;
    tmo_cnt_nxt  = tmo_cnt;

    if (state == RECV) begin
      if (fire) begin
        // A handshake on the limit cycle still counts; the stream is alive.
        tmo_cnt_nxt = '0;
        if (resp.msg != gcd_exp(idx)) begin
          err_nxt = err_count + 3'd1;
          if (err_count == 3'd0) begin
            fail_idx_nxt = idx;
          end
        end
        idx_nxt = idx + 2'd1;
        if (idx == IDX_LAST) begin
          state_nxt = DONE;
        end
      end else if (tmo_cnt == CNT_LAST) begin
        timeout_nxt = 1'b1;
        state_nxt   = TMO;
      end else begin
        tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
      end
    end
  end

  assign done = (state == DONE) || (state == TMO);
  assign pass = (state == DONE) && (err_count == 3'd0);

endmodule

// File: tb/tb_gcd_sink.sv
module tb_gcd_sink;

  localparam int TMO_CYC = 16;

`ifdef GCD_SINK_STALL_EN
  localparam logic RDY_AFTER_RST = 1'b0;  // seed 8'hA5 has bit0 set
`else
  localparam logic RDY_AFTER_RST = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       done, pass, timeout;
  logic [2:0] err_count;
  logic [1:0] fail_idx;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  gcd_sink_if resp_if ();

  gcd_sink #(.TIMEOUT(TMO_CYC), .NUM_MSGS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .resp      (resp_if.slave),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .timeout   (timeout),
    .fail_idx  (fail_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    resp_if.val = 1'b0;
    resp_if.msg = 16'd0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Present one result and hold it until it is accepted (bounded wait).
  task automatic send(input logic [15:0] m);
    int w;
    resp_if.val = 1'b1;
    resp_if.msg = m;
    w = 0;
    while (resp_if.rdy !== 1'b1 && w < 40) begin
      @(posedge clk);
      #1;
      w++;
    end
    checks++;
    if (resp_if.rdy !== 1'b1) begin
      errors++;
      $display("FAIL send_wait msg=%0d: rdy=%b, required 1 within 40 cycles", m, resp_if.rdy);
    end else begin
      @(posedge clk);
      #1;
    end
    resp_if.val = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL rst_pass got=%b exp=0", pass); end
    checks++; if (err_count !== 3'd0) begin errors++; $display("FAIL rst_err got=%0d exp=0", err_count); end
    checks++; if (fail_idx !== 2'd0) begin errors++; $display("FAIL rst_fail_idx got=%0d exp=0", fail_idx); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got=%b exp=0", timeout); end
    checks++; if (resp_if.rdy !== RDY_AFTER_RST) begin errors++; $display("FAIL rst_rdy got=%b exp=%b", resp_if.rdy, RDY_AFTER_RST); end
  endtask

  task automatic test_all_match();
    int t0;
    do_reset();
    t0 = cyc;
    send(16'd5);
    send(16'd2);
    send(16'd18);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL match_done_early got=%b exp=0", done); end
    send(16'd3);
`ifndef GCD_SINK_STALL_EN
    checks++; if (cyc - t0 !== 4) begin errors++; $display("FAIL match_cycles got=%0d exp=4", cyc - t0); end
`endif
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL match_done got=%b exp=1", done); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL match_pass got=%b exp=1", pass); end
    checks++; if (err_count !== 3'd0) begin errors++; $display("FAIL match_err got=%0d exp=0", err_count); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL match_timeout got=%b exp=0", timeout); end
  endtask

  task automatic test_mismatch();
    do_reset();
    send(16'd5);
    checks++; if (err_count !== 3'd0) begin errors++; $display("FAIL mm_err0 got=%0d exp=0", err_count); end
    send(16'd7);
    checks++; if (err_count !== 3'd1) begin errors++; $display("FAIL mm_err1 got=%0d exp=1", err_count); end
    checks++; if (fail_idx !== 2'd1) begin errors++; $display("FAIL mm_idx1 got=%0d exp=1", fail_idx); end
    send(16'd18);
    send(16'd9);
    checks++; if (err_count !== 3'd2) begin errors++; $display("FAIL mm_err2 got=%0d exp=2", err_count); end
    checks++; if (fail_idx !== 2'd1) begin errors++; $display("FAIL mm_idx_final got=%0d exp=1", fail_idx); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mm_done got=%b exp=1", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL mm_pass got=%b exp=0", pass); end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (TMO_CYC - 1) @(posedge clk);
    #1;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_early got=%b exp=0", timeout); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL tmo_done_early got=%b exp=0", done); end
    @(posedge clk);
    #1;
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_flag got=%b exp=1", timeout); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL tmo_done got=%b exp=1", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL tmo_pass got=%b exp=0", pass); end
    checks++; if (resp_if.rdy !== 1'b0) begin errors++; $display("FAIL tmo_rdy got=%b exp=0", resp_if.rdy); end
    resp_if.val = 1'b1;
    resp_if.msg = 16'd5;
    repeat (5) @(posedge clk);
    #1;
    resp_if.val = 1'b0;
    checks++;
    if ({resp_if.rdy, err_count, timeout, done} !== {1'b0, 3'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL tmo_hold rdy/err/tmo/done got=%b/%0d/%b/%b exp=0/0/1/1", resp_if.rdy, err_count, timeout, done);
    end
  endtask

`ifndef GCD_SINK_STALL_EN
  // Handshake on the limit cycle must win and restart the count.
  task automatic test_fire_wins();
    do_reset();
    repeat (TMO_CYC - 1) @(posedge clk);
    #1;
    resp_if.val = 1'b1;
    resp_if.msg = 16'd5;
    @(posedge clk);
    #1;
    resp_if.val = 1'b0;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL fw_timeout got=%b exp=0", timeout); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL fw_done got=%b exp=0", done); end
    repeat (TMO_CYC - 1) @(posedge clk);
    #1;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL fw_restart got=%b exp=0", timeout); end
    @(posedge clk);
    #1;
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL fw_second_tmo got=%b exp=1", timeout); end
    checks++; if (err_count !== 3'd0) begin errors++; $display("FAIL fw_err got=%0d exp=0", err_count); end
  endtask
`endif

  task automatic test_reset_midstream();
    do_reset();
    send(16'd5);
    send(16'd9);
    checks++; if (err_count !== 3'd1) begin errors++; $display("FAIL mid_err_before got=%0d exp=1", err_count); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (err_count !== 3'd0) begin errors++; $display("FAIL mid_err_after got=%0d exp=0", err_count); end
    checks++; if (fail_idx !== 2'd0) begin errors++; $display("FAIL mid_fail_idx got=%0d exp=0", fail_idx); end
    send(16'd5);
    send(16'd2);
    send(16'd18);
    send(16'd3);
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL mid_pass got=%b exp=1", pass); end
    checks++; if (err_count !== 3'd0) begin errors++; $display("FAIL mid_err_final got=%0d exp=0", err_count); end
  endtask

  // Runs right after a passing sequence; sink sits in DONE.
  task automatic test_hold_after_done();
    resp_if.val = 1'b1;
    resp_if.msg = 16'd99;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({resp_if.rdy, err_count, pass, done} !== {1'b0, 3'd0, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL hold_%0d rdy/err/pass/done got=%b/%0d/%b/%b exp=0/0/1/1", i, resp_if.rdy, err_count, pass, done);
      end
    end
    resp_if.val = 1'b0;
  endtask

`ifdef GCD_SINK_STALL_EN
  task automatic test_stall();
    logic [15:0] exp_tab [4];
    logic [7:0]  m;
    int          fires;
    int          stalls;
    exp_tab = '{16'd5, 16'd2, 16'd18, 16'd3};
    do_reset();
    m      = 8'hA5;
    fires  = 0;
    stalls = 0;
    resp_if.val = 1'b1;
    resp_if.msg = exp_tab[0];
    for (int c = 0; c < 100 && fires < 4; c++) begin
      checks++;
      if (resp_if.rdy !== ~m[0]) begin
        errors++;
        $display("FAIL stall_rdy cyc=%0d got=%b exp=%b", c, resp_if.rdy, ~m[0]);
      end
      if (resp_if.rdy === 1'b1) fires++;
      else stalls++;
      @(posedge clk);
      #1;
      m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
      if (fires < 4) resp_if.msg = exp_tab[fires];
    end
    resp_if.val = 1'b0;
    checks++; if (fires !== 4) begin errors++; $display("FAIL stall_fires got=%0d exp=4", fires); end
    checks++; if (stalls == 0) begin errors++; $display("FAIL stall_seen got=%0d exp>0", stalls); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL stall_pass got=%b exp=1", pass); end
    checks++; if (err_count !== 3'd0) begin errors++; $display("FAIL stall_err got=%0d exp=0", err_count); end
  endtask
`endif

  initial begin
    resp_if.val = 1'b0;
    resp_if.msg = 16'd0;
    test_reset();
    test_all_match();
    test_hold_after_done();
    test_mismatch();
    test_timeout();
`ifndef GCD_SINK_STALL_EN
    test_fire_wins();
`endif
    test_reset_midstream();
`ifdef GCD_SINK_STALL_EN
    test_stall();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
